// File: rtl/weighted_resource_arbiter.sv
// Weighted round-robin arbiter. One requester owns the resource for up to max(weight,1)
// cycles. Hand-off to the next requester happens on the same edge, with no idle cycle.
module weighted_resource_arbiter #(
  parameter int N  = 8,
  parameter int WW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    request,
  input  logic [N*WW-1:0] weight,
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   grant_id,
  output logic            grant_valid
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            valid_q, valid_d;

  logic            issue;
  logic            release_own;
  logic [IW-1:0]   start;
  logic [IW-1:0]   pick_idx;

  // Modular increment that stays correct for non-power-of-two N.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(N-1)) ? '0 : i + IW'(1);
  endfunction

  // First requester at or after start, wrapping. start itself is scanned first.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] req, input logic [IW-1:0] s);
    logic [IW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    idx   = s;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
  endfunction

  function automatic logic [WW-1:0] quantum(input logic [IW-1:0] i);
    logic [WW-1:0] w;
    w = weight[i*WW +: WW];
    return (w == '0) ? WW'(1) : w;
  endfunction

  assign pick_idx = pick(request, start);

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    valid_d     = valid_q;
    issue       = 1'b0;
    start       = ptr_q;
    release_own = !request[own_q] || (cnt_q == WW'(1));

    case (state_q)
      IDLE: begin
        if (|request) begin
          issue = 1'b1;
          start = ptr_q;
        end
      end
      BUSY: begin
        if (release_own) begin
          ptr_d = next_idx(own_q);
          if (|request) begin
            // The current owner is scanned last, so it wins again only when it is the sole requester.
            issue = 1'b1;
            start = next_idx(own_q);
          end else begin
            state_d = IDLE;
            own_d   = '0;
            cnt_d   = '0;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      state_d = BUSY;
      own_d   = pick_idx;
      cnt_d   = quantum(pick_idx);
      grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = own_q;
  assign grant_valid = valid_q;

  a_valid_matches: assert property (@(posedge clk) disable iff (rst) grant_valid == (|grant));
  a_owner_granted: assert property (@(posedge clk) disable iff (rst) grant_valid |-> grant[grant_id]);
  a_onehot:        assert property (@(posedge clk) disable iff (rst) $onehot0(grant));

endmodule

// File: doc/weighted_resource_arbiter.md
# weighted_resource_arbiter

Parametrised weighted round-robin arbiter that grants one of `N` requesters exclusive use of a shared resource. It is the successor to the plain round-robin shared-resource arbiter. Each requester holds its grant for a programmable quantum of up to `weight` cycles, or less if it drops its request. Grants are registered one-hot, with an encoded owner index and a valid flag, and it drops into the same fabric slot as the existing arbiter.

## Interface
- `N`, 8: number of requesters, N ≥ 2.
- `WW`, 4: width of each per-requester weight field.
- `IW`, $clog2(N): width of `grant_id`.

- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `request`  in  N: per-requester request level; bit i = requester i.
- `weight`  in  N*WW: packed quanta; requester i uses bits [i*WW +: WW]. Value 0 is treated as 1.
- `grant`  out  N: registered one-hot grant, or all-zero when idle.
- `grant_id`  out  IW: index of current owner; 0 when idle.
- `grant_valid`  out  1: high whenever `grant` is non-zero.

## Operation
- Internal state:
  - FSM with states IDLE and BUSY.
  - Owner index `own`.
  - Round-robin pointer `ptr` (IW bits).
  - Quantum counter `cnt` (WW bits).
- Selection function `pick(start)` returns the first i with `request[i]`=1, scanning start, start+1, …, N-1, 0, …, start-1 (mod N).
- IDLE, at the edge:
  - If `request` ≠ 0: set `own`=`pick(ptr)`, load `cnt`=max(weight[own],1), assert `grant[own]`, go to BUSY.
  - Otherwise stay in IDLE with outputs zero.
- BUSY, at the edge, release occurs when `request[own]`=0 or `cnt`=1. On release:
  - Set `ptr`=(own+1) mod N.
  - If `request` ≠ 0, regrant back-to-back with `own`=`pick((own+1) mod N)`. The current owner is eligible only if it is the sole requester, since it is scanned last. Reload `cnt` and stay in BUSY with no idle cycle.
  - Otherwise clear `grant` and go to IDLE.
- BUSY, at the edge, with no release: `cnt` decrements and the grant holds.
- `weight` is sampled only when a grant is issued. Changes mid-quantum take effect on the next grant.
- Requests from non-owners never pre-empt the owner.
- `grant` is always one-hot or zero. Assertion: `grant_valid` == |`grant`, and `grant[grant_id]` = 1 when valid.
- `ptr` wraps from N-1 to 0. Scan wrap is modular for any N, including non-power-of-two N.

## Timing
- Reset (synchronous, `rst`=1 at an edge): `grant`=0, `grant_id`=0, `grant_valid`=0, `ptr`=0, `cnt`=0, state IDLE.
  - Reset wins over every other event, including mid-quantum.
  - The first grant after reset can occur at the first edge with `rst`=0 and `request` ≠ 0.
- Latency: request sampled high at edge k in IDLE → `grant` high after edge k (visible in cycle k+1).
- Quantum: a persistent owner holds `grant` for exactly max(weight,1) cycles.
- Early release: request sampled low at edge k → `grant` low (or handed over) after edge k. This gives one cycle of grant overlap with the deasserted request, which is inherent to registered grants.
- Handover between owners is zero-bubble.
- Simultaneous release and new requests are resolved at the same edge, using the updated start point (own+1).

## Test plan
- Reset mid-quantum: requester 2 granted with weight 5, `rst` asserted on its 3rd cycle.
  - Required: all outputs 0 after that edge.
  - Required: after release with `request[2]` still high, `grant`=8'b0000_0100 one cycle later with a full 5-cycle quantum.
- Single persistent request: `request`=8'b0000_0001, weight[0]=3, held 9 cycles.
  - Required: `grant`=8'b0000_0001 continuously, `grant_id`=0.
  - Required: `cnt` reloads every 3 cycles; `ptr` observes 1 after each release.
- Weighted mix: `request`=8'b0000_1011, weights {w0=2, w1=1, w3=3}, held.
  - Required owner sequence per cycle: 0,0,1,3,3,3,0,0,1,3,3,3.
- All request, all weights 1 (and separately all weights 0).
  - Required: `grant_id` cycles 0,1,…,7,0,… one per cycle, no bubbles.
- Transient request from idle: `request`=8'b1000_0000 for one cycle, then 0.
  - Required: `grant`=8'b1000_0000 for exactly one cycle (the cycle after the pulse), `grant_id`=7, then idle; `ptr`=0 afterward.
- Early release and wrap: `request`=8'b1000_0011, weight[7]=4.
  - While 7 owns, drop bit 7 after 2 cycles.
  - Required: 7 granted 2 cycles, then an immediate handover to 0 (pointer wraps 7→0), then 1.
